// File: rtl/uart_pkg.sv
// Shared UART constants and types, common to the RX, TX and receive-FIFO blocks.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_START_BITS = 1;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: one push per rx_done level, first-word
// fall-through read side, sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_BITS,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  rx_done_q;
  logic                  push_req, push, pop;

  assign m_valid  = (count_q != '0);
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
  always_comb begin
    push_req   = rx_done && !rx_done_q;
    pop        = m_valid && m_ready;
    push       = push_req && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // rx_done_q resets high so a done level already present at release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_done_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_done_q  <= rx_done;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(rx_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(m_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model feeds expected
// bytes and flags; a negedge monitor compares them with what the DUT presents.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int            modelCount = 0;
  bit            modelOvf = 1'b0;
  bit            prevDone = 1'b1;
  logic [DW-1:0] expQ [$];

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise rx_done for 'hold' cycles with a byte; optionally pulse overflow_clr on the push edge.
  task automatic applyStimulus(input logic [DW-1:0] d, input int hold, input bit clr);
    rx_data      = d;
    rx_done      = 1'b1;
    overflow_clr = clr;
    tick();
    overflow_clr = 1'b0;
    repeat (hold - 1) tick();
    rx_done = 1'b0;
    tick();
  endtask

  // Reference model: a byte queue with capacity DEPTH, one push per rx_done rise.
  always @(posedge clk) begin
    bit pushReq;
    bit popNow;
    bit setOvf;
    if (rst) begin
      modelCount = 0;
      modelOvf   = 1'b0;
      prevDone   = 1'b1;
      expQ.delete();
    end else begin
      pushReq  = rx_done && !prevDone;
      prevDone = rx_done;
      popNow   = (modelCount > 0) && m_ready;
      setOvf   = 1'b0;
      if (pushReq && (modelCount < DEPTH || popNow)) begin
        expQ.push_back(rx_data);
        modelCount++;
      end else if (pushReq) begin
        setOvf = 1'b1;
      end
      if (popNow) modelCount--;
      if (setOvf) modelOvf = 1'b1;
      else if (overflow_clr) modelOvf = 1'b0;
    end
  end

  // Monitor: flags every cycle, data on every handshake the DUT offers.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m_valid", 32'(m_valid), 32'(modelCount != 0));
      checkOutput("count", 32'(count), 32'(modelCount));
      checkOutput("full", 32'(full), 32'(modelCount == DEPTH));
      checkOutput("empty", 32'(empty), 32'(modelCount == 0));
      checkOutput("overflow", 32'(overflow), 32'(modelOvf));
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) checkOutput("pop with nothing expected", 32'(m_valid), 32'd0);
        else checkOutput("m_data", 32'(m_data), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    int readyBias;
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'h41; m_ready = 1'b0; overflow_clr = 1'b0;
    tick();
    checking = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("no push from done held through reset", 32'(count), 32'd0);
    rx_done = 1'b0;
    tick();

    $display("[TB] single push from long rx_done level");
    applyStimulus(8'h41, 50, 1'b0);
    checkOutput("one push count", 32'(count), 32'd1);
    checkOutput("one push data", 32'(m_data), 32'h41);
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;

    $display("[TB] four bytes then back-to-back drain");
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h41 + i), 3, 1'b0);
    checkOutput("four pushed", 32'(count), 32'd4);
    m_ready = 1'b1;
    repeat (5) tick();
    m_ready = 1'b0;
    checkOutput("empty after drain", 32'(empty), 32'd1);

    $display("[TB] overflow with seventeen pushes");
    for (int i = 1; i <= 17; i++) applyStimulus(8'(i), 2, 1'b0);
    checkOutput("full flag", 32'(full), 32'd1);
    checkOutput("full count", 32'(count), 32'd16);
    checkOutput("overflow set", 32'(overflow), 32'd1);
    applyStimulus(8'h77, 2, 1'b1);
    checkOutput("set beats clear", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("clear alone", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    repeat (16) tick();
    m_ready = 1'b0;
    checkOutput("drained after overflow", 32'(empty), 32'd1);

    $display("[TB] push and pop together while full");
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'hA0 + i), 2, 1'b0);
    rx_data = 8'hEE; rx_done = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("full push+pop count", 32'(count), 32'd16);
    checkOutput("full push+pop no overflow", 32'(overflow), 32'd0);
    rx_done = 1'b0;
    tick();
    m_ready = 1'b1;
    repeat (17) tick();
    m_ready = 1'b0;

    $display("[TB] reset mid-operation with rx_done held");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h50 + i), 2, 1'b0);
    checkOutput("five stored", 32'(count), 32'd5);
    rx_data = 8'h99; rx_done = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("count after reset", 32'(count), 32'd0);
    checkOutput("valid after reset", 32'(m_valid), 32'd0);
    rx_done = 1'b0;
    tick();
    applyStimulus(8'h99, 3, 1'b0);
    checkOutput("push after done re-rises", 32'(count), 32'd1);
    m_ready = 1'b1;
    repeat (2) tick();

    $display("[TB] randomized traffic");
    readyBias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) readyBias = int'($urandom_range(0, 4));
      m_ready      = ($urandom_range(0, 3) < readyBias);
      overflow_clr = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 799) == 0);
      if (rx_done) begin
        if ($urandom_range(0, 2) == 0) rx_done = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
      end
      tick();
    end
    rst = 1'b0; overflow_clr = 1'b0; rx_done = 1'b0; m_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    checkOutput("final empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: received byte width.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH): pointer width.
REQ-004 SHALL have port clk  input  1: single clock for all logic.
REQ-005 SHALL have port rst  input  1: synchronous active-high reset.
REQ-006 SHALL have port rx_data  input  DATA_WIDTH: byte from upstream UART receiver; stable while rx_done is high.
REQ-007 SHALL have port rx_done  input  1: receiver done level; may stay high for many cycles per byte.
REQ-008 SHALL have port m_data  output  DATA_WIDTH: head-of-FIFO byte (first-word fall-through).
REQ-009 SHALL have port m_valid  output  1: m_data holds a valid byte.
REQ-010 SHALL have port m_ready  input  1: consumer accepts m_data.
REQ-011 SHALL have port count  output  ADDR_WIDTH+1: number of bytes stored.
REQ-012 SHALL have port full  output  1: count equals DEPTH.
REQ-013 SHALL have port empty  output  1: count equals 0.
REQ-014 SHALL have port overflow  output  1: sticky; one or more bytes dropped.
REQ-015 SHALL have port overflow_clr  input  1: one-cycle pulse that clears overflow.

Function
REQ-016 SHALL register rx_done into rx_done_d each cycle; push request = rx_done AND NOT rx_done_d, so each high level of rx_done gives exactly one push.
REQ-017 SHALL write rx_data to mem[wr_ptr] on the push-request edge when not full, or when full with a pop in the same cycle.
REQ-018 SHALL drive m_valid high from the cycle after the write that made count non-zero (push-to-valid latency 1 cycle).
REQ-019 SHALL drive m_data combinationally from mem[rd_ptr]; m_data is don't-care while m_valid is low.
REQ-020 SHALL pop when m_valid AND m_ready; m_ready while empty has no effect.
REQ-021 SHALL leave count unchanged on simultaneous push and pop, +1 on push only, -1 on pop only.
REQ-022 SHALL advance wr_ptr and rd_ptr modulo DEPTH; wrap from DEPTH-1 to 0 is seamless.
REQ-023 SHALL drop a push request when full with no pop in that cycle; mem, wr_ptr and count stay unchanged, and overflow is set on the next edge.
REQ-024 SHALL hold overflow until an overflow_clr pulse; if set and clear fall in the same cycle, set wins.
REQ-025 SHALL accept a push while empty even with m_ready high; the byte is not popped in the push cycle.
REQ-026 SHALL derive full and empty from count, never from the pointers alone.

Reset
REQ-027 SHALL clear wr_ptr, rd_ptr, count and overflow on the rst edge; m_valid=0, empty=1, full=0.
REQ-028 SHALL reset rx_done_d to 1, so an rx_done already high at reset release causes no push.
REQ-029 SHALL let reset mid-operation discard all stored bytes; mem contents are not cleared.
REQ-030 SHALL give rst priority over push, pop and overflow_clr.

Structure
REQ-031 SHALL take the DATA_WIDTH default and UART framing constants from shared package uart_pkg, the same package used by the UART RX/TX blocks.
REQ-032 SHALL place storage in sub-module uart_fifo_mem (synchronous write, asynchronous read); pointers, count and flags stay in uart_rx_fifo.

Verification
REQ-033 Reset, then rx_data=0x41 with rx_done high for 50 cycles, m_ready=0 -> exactly one push; m_valid=1 one cycle after the edge; m_data=0x41; count=1.
REQ-034 Push 0x41..0x44, then m_ready=1 -> m_data sequence 0x41,0x42,0x43,0x44 on consecutive cycles; empty=1 afterwards.
REQ-035 DEPTH=16, m_ready=0, 17 pushes -> full=1, count=16, overflow=1, byte 17 absent; pop 16 yields bytes 1..16 in order.
REQ-036 Full, then push edge and m_ready=1 in the same cycle -> count stays 16, overflow stays 0, new byte read out last.
REQ-037 Assert rst with count=5 while rx_done is held high -> count=0, m_valid=0, overflow=0, and no push after release until rx_done falls and rises again.
REQ-038 overflow=1, then overflow_clr pulse coinciding with a dropped push -> overflow remains 1; clear alone -> 0 next cycle.
